// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals of mem_port_arbiter.
// master is the arbiter's view; slave is the processor-plus-memory side.
interface mem_port_arbiter_if #(
   parameter int AW = 10,
   parameter int DW = 32
);
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_rdata;
   logic          i_ack;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_ack;
   logic          m_en;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;
   logic          m_ack;
   logic          busy;
   logic          err;

   modport master (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
      output i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_addr, m_wdata, busy, err
   );

   modport slave (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
      input  i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_addr, m_wdata, busy, err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch (I) and load/store (D) ports,
// with alternating priority under contention and a timeout against a hung memory.
//
// state  | meaning
// IDLE   | waiting for a request; grants one when seen
// BUSY   | m_en high, latched request held until m_ack or timeout
// RESP   | one-cycle ack to the winner, requests ignored
module mem_port_arbiter #(
   parameter int              AW       = 10,
   parameter int              DW       = 32,
   parameter int              TIMEOUT  = 15,
   parameter logic [DW-1:0]   ERR_DATA = 32'hDEADBEEF
) (
   input  logic               clk,
   input  logic               reset,
   mem_port_arbiter_if.master bus
);
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t        state_q, state_d;
   logic          last_d_q, last_d_d;
   logic          win_d_q, win_d_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          m_en_q, m_en_d;
   logic          m_we_q, m_we_d;
   logic [AW-1:0] m_addr_q, m_addr_d;
   logic [DW-1:0] m_wdata_q, m_wdata_d;
   logic          i_ack_q, i_ack_d;
   logic          d_ack_q, d_ack_d;
   logic [DW-1:0] i_rdata_q, i_rdata_d;
   logic [DW-1:0] d_rdata_q, d_rdata_d;
   logic          busy_q, busy_d;
   logic          err_q, err_d;
   logic          grant_is_d;
   logic [DW-1:0] resp_data;

   always_comb begin
      state_d    = state_q;
      last_d_d   = last_d_q;
      win_d_d    = win_d_q;
      cnt_d      = cnt_q;
      m_en_d     = m_en_q;
      m_we_d     = m_we_q;
      m_addr_d   = m_addr_q;
      m_wdata_d  = m_wdata_q;
      i_ack_d    = 1'b0;
      d_ack_d    = 1'b0;
      i_rdata_d  = i_rdata_q;
      d_rdata_d  = d_rdata_q;
      busy_d     = busy_q;
      err_d      = err_q;
      grant_is_d = bus.d_req && (!bus.i_req || !last_d_q);
      resp_data  = bus.m_ack ? bus.m_rdata : ERR_DATA;

      case (state_q)
         S_IDLE: begin
            if (bus.i_req || bus.d_req) begin
               win_d_d   = grant_is_d;
               last_d_d  = grant_is_d;
               m_addr_d  = grant_is_d ? bus.d_addr : bus.i_addr;
               m_we_d    = grant_is_d && bus.d_we;
               m_wdata_d = grant_is_d ? bus.d_wdata : '0;
               cnt_d     = 8'd0;
               m_en_d    = 1'b1;
               busy_d    = 1'b1;
               state_d   = S_BUSY;
            end
         end
         S_BUSY: begin
            // a real m_ack wins over a timeout landing in the same cycle
            if (bus.m_ack || cnt_q == CNT_LAST) begin
               if (win_d_q) d_rdata_d = resp_data;
               else         i_rdata_d = resp_data;
               if (!bus.m_ack) err_d = 1'b1;
               i_ack_d = !win_d_q;
               d_ack_d = win_d_q;
               m_en_d  = 1'b0;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_RESP: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            m_en_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         last_d_q  <= 1'b0;
         win_d_q   <= 1'b0;
         cnt_q     <= 8'd0;
         m_en_q    <= 1'b0;
         m_we_q    <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         i_ack_q   <= 1'b0;
         d_ack_q   <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_d_q  <= last_d_d;
         win_d_q   <= win_d_d;
         cnt_q     <= cnt_d;
         m_en_q    <= m_en_d;
         m_we_q    <= m_we_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         i_ack_q   <= i_ack_d;
         d_ack_q   <= d_ack_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
      end
   end

   assign bus.m_en    = m_en_q;
   assign bus.m_we    = m_we_q;
   assign bus.m_addr  = m_addr_q;
   assign bus.m_wdata = m_wdata_q;
   assign bus.i_ack   = i_ack_q;
   assign bus.d_ack   = d_ack_q;
   assign bus.i_rdata = i_rdata_q;
   assign bus.d_rdata = d_rdata_q;
   assign bus.busy    = busy_q;
   assign bus.err     = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a behavioural memory responds on the m_* side while
// a reference model of the arbitration rules predicts winner, latency and data.
module tb_mem_port_arbiter;
   localparam int          AW      = 10;
   localparam int          DW      = 32;
   localparam int          TIMEOUT = 15;
   localparam logic [31:0] ERRD    = 32'hDEADBEEF;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .ERR_DATA(ERRD)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   logic [31:0] mem_arr [1024];
   logic [31:0] ref_mem [1024];
   int n_vec = 0;
   int n_err = 0;

   bit          m_last_d;
   logic [31:0] exp_i_rd, exp_d_rd;

   int          r_en_cycles, r_ack_iter;
   bit          r_got_i, r_got_d, r_both, r_stable, r_we0, r_post_busy, r_post_ack;
   logic [9:0]  r_addr0;
   logic [31:0] r_wdata0, r_rd;

   function automatic bit pick_d(input bit ir, input bit dr, input bit last_was_d);
      if (ir && dr) return !last_was_d;
      return dr;
   endfunction

   task automatic set_req(input bit ir, input logic [9:0] ia, input bit dr, input bit dwe,
                          input logic [9:0] da, input logic [31:0] dwd);
      bus.i_req = ir; bus.i_addr = ia;
      bus.d_req = dr; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = dwd;
   endtask

   // Memory responder: acks after lat BUSY cycles (lat<0 never acks). Returns at the IDLE cycle.
   task automatic run_access(input int lat);
      r_en_cycles = 0; r_ack_iter = 0; r_got_i = 0; r_got_d = 0; r_both = 0;
      r_stable = 1; r_rd = '0; r_we0 = 0; r_addr0 = '0; r_wdata0 = '0;
      for (int it = 1; it <= 60; it++) begin
         @(negedge clk);
         bus.m_ack = 1'b0;
         if (bus.i_ack && bus.d_ack) r_both = 1;
         if (bus.i_ack || bus.d_ack) begin
            r_got_i = bus.i_ack; r_got_d = bus.d_ack;
            r_rd = bus.i_ack ? bus.i_rdata : bus.d_rdata;
            r_ack_iter = it;
            break;
         end
         if (bus.m_en) begin
            r_en_cycles++;
            if (r_en_cycles == 1) begin
               r_we0 = bus.m_we; r_addr0 = bus.m_addr; r_wdata0 = bus.m_wdata;
            end else if (bus.m_we !== r_we0 || bus.m_addr !== r_addr0 || bus.m_wdata !== r_wdata0) begin
               r_stable = 0;
            end
            if (r_en_cycles - 1 == lat) begin
               bus.m_ack = 1'b1;
               bus.m_rdata = mem_arr[bus.m_addr];
               if (bus.m_we) mem_arr[bus.m_addr] = bus.m_wdata;
            end else begin
               bus.m_rdata = $urandom;
            end
         end
      end
      if (r_ack_iter == 0) begin
         n_vec++; n_err++;
         $display("FAIL ack_wait: no ack within 60 cycles, required one");
      end
      @(negedge clk);
      bus.m_ack = 1'b0;
      r_post_busy = bus.busy;
      r_post_ack = bus.i_ack | bus.d_ack;
   endtask

   task automatic test_reset();
      logic [135:0] outs;
      #3;
      outs = {bus.m_en, bus.m_we, bus.m_addr, bus.m_wdata, bus.i_ack, bus.d_ack,
              bus.i_rdata, bus.d_rdata, bus.busy, bus.err};
      n_vec++;
      if (outs !== '0) begin
         n_err++; $display("FAIL reset_outputs: got %h required 0", outs);
      end
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      m_last_d = 0; exp_i_rd = '0; exp_d_rd = '0;
   endtask

   task automatic test_fetch();
      mem_arr[4] = 32'h20080005; ref_mem[4] = 32'h20080005;
      set_req(1, 10'h004, 0, 0, '0, '0);
      run_access(0);
      set_req(0, '0, 0, 0, '0, '0);
      m_last_d = 0; exp_i_rd = 32'h20080005;
      n_vec++;
      if (r_en_cycles != 1) begin n_err++; $display("FAIL fetch_en_cycles: got %0d required 1", r_en_cycles); end
      n_vec++;
      if (r_ack_iter != 2) begin n_err++; $display("FAIL fetch_ack_latency: got %0d required 2", r_ack_iter); end
      n_vec++;
      if (!r_got_i || r_got_d) begin n_err++; $display("FAIL fetch_port: got i=%0b d=%0b required i=1 d=0", r_got_i, r_got_d); end
      n_vec++;
      if (r_rd !== 32'h20080005) begin n_err++; $display("FAIL fetch_rdata: got %h required 20080005", r_rd); end
      n_vec++;
      if (r_addr0 !== 10'h004 || r_we0 !== 1'b0) begin n_err++; $display("FAIL fetch_maddr: got %h we=%0b required 004 we=0", r_addr0, r_we0); end
      n_vec++;
      if (r_post_busy !== 1'b0) begin n_err++; $display("FAIL fetch_idle_busy: got %0b required 0", r_post_busy); end
   endtask

   task automatic test_contention();
      bit wd;
      int lat;
      set_req(1, 10'h100, 1, 0, 10'h200, '0);
      for (int k = 0; k < 4; k++) begin
         wd = pick_d(1, 1, m_last_d);
         m_last_d = wd;
         lat = $urandom_range(0, 2);
         run_access(lat);
         n_vec++;
         if (r_got_d !== wd || r_got_i !== !wd || r_both) begin
            n_err++; $display("FAIL contention_winner[%0d]: got i=%0b d=%0b both=%0b required d=%0b", k, r_got_i, r_got_d, r_both, wd);
         end
         n_vec++;
         if (r_rd !== ref_mem[wd ? 10'h200 : 10'h100] || r_addr0 !== (wd ? 10'h200 : 10'h100)) begin
            n_err++; $display("FAIL contention_data[%0d]: got %h @%h required %h", k, r_rd, r_addr0, ref_mem[wd ? 10'h200 : 10'h100]);
         end
         n_vec++;
         if (r_ack_iter != lat + 2) begin n_err++; $display("FAIL contention_latency[%0d]: got %0d required %0d", k, r_ack_iter, lat + 2); end
         if (wd) exp_d_rd = ref_mem[10'h200]; else exp_i_rd = ref_mem[10'h100];
      end
      set_req(0, '0, 0, 0, '0, '0);
   endtask

   task automatic test_write();
      set_req(0, '0, 1, 1, 10'h010, 32'h12345678);
      run_access(3);
      exp_d_rd = ref_mem[10'h010];
      ref_mem[10'h010] = 32'h12345678;
      m_last_d = 1;
      n_vec++;
      if (r_en_cycles != 4 || !r_stable) begin n_err++; $display("FAIL write_en_stable: got %0d cycles stable=%0b required 4 stable=1", r_en_cycles, r_stable); end
      n_vec++;
      if (r_we0 !== 1'b1 || r_wdata0 !== 32'h12345678 || r_addr0 !== 10'h010) begin
         n_err++; $display("FAIL write_operands: got we=%0b %h @%h required we=1 12345678 @010", r_we0, r_wdata0, r_addr0);
      end
      n_vec++;
      if (!r_got_d || r_ack_iter != 5) begin n_err++; $display("FAIL write_ack: got d=%0b at %0d required d=1 at 5", r_got_d, r_ack_iter); end
      set_req(0, '0, 1, 0, 10'h010, '0);
      run_access($urandom_range(0, 3));
      set_req(0, '0, 0, 0, '0, '0);
      exp_d_rd = ref_mem[10'h010];
      n_vec++;
      if (!r_got_d || r_rd !== 32'h12345678) begin n_err++; $display("FAIL write_readback: got %h required 12345678", r_rd); end
   endtask

   task automatic test_timeout();
      set_req(0, '0, 1, 0, 10'h020, '0);
      run_access(-1);
      set_req(0, '0, 0, 0, '0, '0);
      exp_d_rd = ERRD; m_last_d = 1;
      n_vec++;
      if (r_en_cycles != TIMEOUT) begin n_err++; $display("FAIL timeout_en_cycles: got %0d required %0d", r_en_cycles, TIMEOUT); end
      n_vec++;
      if (!r_got_d || r_ack_iter != TIMEOUT + 1) begin n_err++; $display("FAIL timeout_ack: got d=%0b at %0d required d=1 at %0d", r_got_d, r_ack_iter, TIMEOUT + 1); end
      n_vec++;
      if (r_rd !== ERRD) begin n_err++; $display("FAIL timeout_rdata: got %h required %h", r_rd, ERRD); end
      n_vec++;
      if (bus.err !== 1'b1) begin n_err++; $display("FAIL timeout_err: got %0b required 1", bus.err); end
      set_req(1, 10'h004, 0, 0, '0, '0);
      run_access(1);
      set_req(0, '0, 0, 0, '0, '0);
      exp_i_rd = ref_mem[10'h004]; m_last_d = 0;
      n_vec++;
      if (bus.err !== 1'b1 || r_rd !== ref_mem[10'h004]) begin
         n_err++; $display("FAIL timeout_err_sticky: got err=%0b rd=%h required err=1 rd=%h", bus.err, r_rd, ref_mem[10'h004]);
      end
   endtask

   task automatic test_reset_mid();
      bit bad_ack;
      set_req(0, '0, 1, 0, 10'h030, '0);
      @(negedge clk); @(negedge clk);
      n_vec++;
      if (bus.m_en !== 1'b1 || bus.err !== 1'b1) begin n_err++; $display("FAIL rstmid_pre: got m_en=%0b err=%0b required 1 1", bus.m_en, bus.err); end
      #2 reset = 1'b0;
      #1;
      n_vec++;
      if ({bus.m_en, bus.busy, bus.err, bus.i_ack, bus.d_ack} !== 5'b0) begin
         n_err++; $display("FAIL rstmid_clear: got en/busy/err/ia/da=%b required 00000", {bus.m_en, bus.busy, bus.err, bus.i_ack, bus.d_ack});
      end
      bad_ack = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (bus.i_ack || bus.d_ack || bus.m_en) bad_ack = 1;
      end
      reset = 1'b1;
      m_last_d = 0; exp_i_rd = '0; exp_d_rd = '0;
      @(negedge clk);
      if (bus.i_ack || bus.d_ack) bad_ack = 1;
      n_vec++;
      if (bad_ack) begin n_err++; $display("FAIL rstmid_no_ack: got a stray ack or m_en, required none"); end
      set_req(1, 10'h040, 1, 0, 10'h030, '0);
      run_access(1);
      set_req(0, '0, 0, 0, '0, '0);
      m_last_d = 1; exp_d_rd = ref_mem[10'h030];
      n_vec++;
      if (!r_got_d || r_got_i || r_rd !== ref_mem[10'h030]) begin
         n_err++; $display("FAIL rstmid_first_grant: got i=%0b d=%0b rd=%h required d=1 rd=%h", r_got_i, r_got_d, r_rd, ref_mem[10'h030]);
      end
   endtask

   task automatic test_idle_ack();
      bit bad;
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         bus.m_ack = 1'b1;
         bus.m_rdata = $urandom;
         @(negedge clk);
         if (bus.i_ack || bus.d_ack || bus.busy || bus.m_en) bad = 1;
      end
      bus.m_ack = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bad) begin n_err++; $display("FAIL idle_ack_response: got ack/busy activity required none"); end
      n_vec++;
      if (bus.i_rdata !== exp_i_rd || bus.d_rdata !== exp_d_rd) begin
         n_err++; $display("FAIL idle_ack_rdata: got i=%h d=%h required i=%h d=%h", bus.i_rdata, bus.d_rdata, exp_i_rd, exp_d_rd);
      end
   endtask

   task automatic test_random();
      bit          pi, pd, pwe, wd;
      logic [9:0]  ia, da, wa;
      logic [31:0] wdat, expv;
      int          lat;
      pi = 0; pd = 0; ia = '0; da = '0; pwe = 0; wdat = '0;
      for (int k = 0; k < 40; k++) begin
         if (!pi && $urandom_range(0, 1) == 1) begin pi = 1; ia = 10'($urandom_range(0, 31)); end
         if (!pd && $urandom_range(0, 1) == 1) begin
            pd = 1; da = 10'($urandom_range(0, 31)); pwe = 1'($urandom); wdat = $urandom;
         end
         if (!pi && !pd) begin pd = 1; da = 10'($urandom_range(0, 31)); pwe = 0; wdat = $urandom; end
         set_req(pi, ia, pd, pwe, da, wdat);
         wd = pick_d(pi, pd, m_last_d);
         m_last_d = wd;
         wa = wd ? da : ia;
         expv = ref_mem[wa];
         lat = $urandom_range(0, 4);
         run_access(lat);
         n_vec++;
         if (r_got_d !== wd || r_got_i !== !wd || r_both) begin
            n_err++; $display("FAIL rand_winner[%0d]: got i=%0b d=%0b required d=%0b", k, r_got_i, r_got_d, wd);
         end
         n_vec++;
         if (r_addr0 !== wa || r_we0 !== (wd && pwe) || (wd && pwe && r_wdata0 !== wdat)) begin
            n_err++; $display("FAIL rand_operands[%0d]: got @%h we=%0b %h required @%h", k, r_addr0, r_we0, r_wdata0, wa);
         end
         n_vec++;
         if (r_en_cycles != lat + 1 || r_ack_iter != lat + 2 || !r_stable) begin
            n_err++; $display("FAIL rand_timing[%0d]: got en=%0d ack=%0d required en=%0d ack=%0d", k, r_en_cycles, r_ack_iter, lat + 1, lat + 2);
         end
         if (!(wd && pwe)) begin
            n_vec++;
            if (r_rd !== expv) begin n_err++; $display("FAIL rand_rdata[%0d]: got %h required %h", k, r_rd, expv); end
         end
         if (wd) begin
            exp_d_rd = expv;
            if (pwe) ref_mem[wa] = wdat;
            pd = 0;
         end else begin
            exp_i_rd = expv;
            pi = 0;
         end
      end
      set_req(0, '0, 0, 0, '0, '0);
      @(negedge clk);
      n_vec++;
      if (bus.i_rdata !== exp_i_rd || bus.d_rdata !== exp_d_rd) begin
         n_err++; $display("FAIL rand_hold: got i=%h d=%h required i=%h d=%h", bus.i_rdata, bus.d_rdata, exp_i_rd, exp_d_rd);
      end
   endtask

   initial begin
      logic [31:0] v;
      for (int k = 0; k < 1024; k++) begin
         v = $urandom; mem_arr[k] = v; ref_mem[k] = v;
      end
      bus.m_ack = 1'b0; bus.m_rdata = '0;
      set_req(0, '0, 0, 0, '0, '0);
      test_reset();
      test_fetch();
      test_contention();
      test_write();
      test_timeout();
      test_reset_mid();
      test_idle_ack();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
